trap_sequencer: RTL and testbench

- Sequences machine-mode trap entry and `mret` return for the core.
- Collects exception requests from the decode, execute and memory stages, plus the external interrupt line, and selects one winner by priority.
- Flushes and stalls the pipeline, waits for drain, then issues a one-cycle commit pulse to the CSR file (`controlReset`/`mcause`/`mtval`/`mepc` inputs) and redirects fetch.
- Sits between pipeline control and the CSR file; it is the only source of CSR trap/`mret` updates.

---
 rtl/trap_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_trap_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: picks one trap source, flushes and drains
// the pipeline, pulses the CSR commit, then redirects fetch.
module trap_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [2:0]  excValid,
    input  logic [11:0] excCause,
    input  logic [95:0] excTval,
    input  logic [95:0] excPC,
    input  logic [31:0] retirePC,
    input  logic        interrupt,
    input  logic        mstatusMie,
    input  logic        mieMeie,
    input  logic        mretRequest,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic        flush,
    output logic        stall,
    output logic        trapCommit,
    output logic [3:0]  trapCause,
    output logic        trapInterrupt,
    output logic [31:0] trapTval,
    output logic [31:0] trapPC,
    output logic        mretCommit,
    output logic        redirectValid,
    output logic [31:0] redirectPC,
    output logic        busy
);

    localparam logic [3:0] IRQ_CAUSE = 4'd11;
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        COMMIT,
        REDIRECT,
        MRET
    } state_t;

    state_t          stateQ, stateD;
    logic [SYNC_STAGES-1:0] syncQ;
    logic [CW-1:0]   cntQ, cntD;
    logic [3:0]      causeQ, causeD;
    logic [31:0]     tvalQ, tvalD;
    logic [31:0]     pcQ, pcD;
    logic            irqQ, irqD;

    logic            irqSync;
    logic            irqTake;
    logic            excAny;
    logic [3:0]      selCause;
    logic [31:0]     selTval;
    logic [31:0]     selPc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[SYNC_STAGES-2:0], interrupt};
        end
    end

    assign irqSync = syncQ[SYNC_STAGES-1];
    assign irqTake = irqSync & mstatusMie & mieMeie;
    assign excAny  = |excValid;

    // Later pipeline stages are older instructions, so memory beats execute beats decode.
    always_comb begin
        selCause = '0;
        selTval  = '0;
        selPc    = '0;
        if (excValid[2]) begin
            selCause = excCause[11:8];
            selTval  = excTval[95:64];
            selPc    = excPC[95:64];
        end else if (excValid[1]) begin
            selCause = excCause[7:4];
            selTval  = excTval[63:32];
            selPc    = excPC[63:32];
        end else if (excValid[0]) begin
            selCause = excCause[3:0];
            selTval  = excTval[31:0];
            selPc    = excPC[31:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
            cntQ   <= '0;
            causeQ <= '0;
            tvalQ  <= '0;
            pcQ    <= '0;
            irqQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            causeQ <= causeD;
            tvalQ  <= tvalD;
            pcQ    <= pcD;
            irqQ   <= irqD;
        end
    end

    always_comb begin
        stateD        = stateQ;
        cntD          = cntQ;
        causeD        = causeQ;
        tvalD         = tvalQ;
        pcD           = pcQ;
        irqD          = irqQ;
        flush         = 1'b0;
        trapCommit    = 1'b0;
        trapCause     = '0;
        trapInterrupt = 1'b0;
        trapTval      = '0;
        trapPC        = '0;
        mretCommit    = 1'b0;
        redirectValid = 1'b0;
        redirectPC    = '0;

        unique case (stateQ)
            IDLE: begin
                if (excAny) begin
                    flush  = 1'b1;
                    stateD = DRAIN;
                    cntD   = DRAIN_LOAD;
                    causeD = selCause;
                    tvalD  = selTval;
                    pcD    = selPc;
                    irqD   = 1'b0;
                end else if (mretRequest) begin
                    flush  = 1'b1;
                    stateD = MRET;
                end else if (irqTake) begin
                    flush  = 1'b1;
                    stateD = DRAIN;
                    cntD   = DRAIN_LOAD;
                    causeD = IRQ_CAUSE;
                    tvalD  = '0;
                    pcD    = retirePC;
                    irqD   = 1'b1;
                end
            end
            DRAIN: begin
                if (cntQ == '0) begin
                    stateD = COMMIT;
                end else begin
                    cntD = cntQ - 1'b1;
                end
            end
            COMMIT: begin
                trapCommit    = 1'b1;
                trapCause     = causeQ;
                trapInterrupt = irqQ;
                trapTval      = tvalQ;
                trapPC        = pcQ;
                stateD        = REDIRECT;
            end
            REDIRECT: begin
                redirectValid = 1'b1;
                redirectPC    = {mtvec[31:2], 2'b00}
                              + (((mtvec[1:0] == 2'b01) && irqQ) ? {26'd0, causeQ, 2'b00} : 32'd0);
                stateD        = IDLE;
            end
            MRET: begin
                mretCommit    = 1'b1;
                redirectValid = 1'b1;
                redirectPC    = mepc;
                stateD        = IDLE;
            end
            default: begin
                stateD = IDLE;
            end
        endcase

        // While reset is held the FSM sits in IDLE, so a pending request must not leak out as a flush.
        if (!reset) begin
            flush = 1'b0;
        end
    end

    assign busy  = (stateQ != IDLE);
    assign stall = busy;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model of trap/mret timing.
module tb_trap_sequencer;

    localparam int D    = 2;
    localparam int SYNC = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  excValid;
    logic [11:0] excCause;
    logic [95:0] excTval;
    logic [95:0] excPC;
    logic [31:0] retirePC;
    logic        interrupt;
    logic        mstatusMie;
    logic        mieMeie;
    logic        mretRequest;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        flush;
    logic        stall;
    logic        trapCommit;
    logic [3:0]  trapCause;
    logic        trapInterrupt;
    logic [31:0] trapTval;
    logic [31:0] trapPC;
    logic        mretCommit;
    logic        redirectValid;
    logic [31:0] redirectPC;
    logic        busy;

    int checks = 0;
    int passes = 0;

    // Model: a pending operation and its age in cycles since the request was accepted.
    bit          mBusy;
    bit          mIsMret;
    int          mAge;
    bit          mIrq;
    logic [3:0]  mCause;
    logic [31:0] mTval;
    logic [31:0] mPc;
    bit          irqQ[$];

    trap_sequencer #(.DRAIN_CYCLES(D), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset(reset), .excValid(excValid), .excCause(excCause),
        .excTval(excTval), .excPC(excPC), .retirePC(retirePC), .interrupt(interrupt),
        .mstatusMie(mstatusMie), .mieMeie(mieMeie), .mretRequest(mretRequest),
        .mtvec(mtvec), .mepc(mepc), .flush(flush), .stall(stall), .trapCommit(trapCommit),
        .trapCause(trapCause), .trapInterrupt(trapInterrupt), .trapTval(trapTval),
        .trapPC(trapPC), .mretCommit(mretCommit), .redirectValid(redirectValid),
        .redirectPC(redirectPC), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearReq();
        excValid    = '0;
        excCause    = '0;
        excTval     = '0;
        excPC       = '0;
        mretRequest = 1'b0;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input int stage, input logic [3:0] cause,
                                 input logic [31:0] tval, input logic [31:0] pc);
        excValid = excValid | v;
        excCause[4*stage +: 4]  = cause;
        excTval[32*stage +: 32] = tval;
        excPC[32*stage +: 32]   = pc;
    endtask

    // Called once per cycle, shortly after the falling edge once inputs are settled.
    task automatic evalCycle();
        logic        eFlush, eBusy, eCommit, eIrq, eMret, eRv;
        logic [3:0]  eCause;
        logic [31:0] eTval, ePc, eRpc;
        bit          sync;
        int          s;
        #1;
        eFlush = 0; eBusy = 0; eCommit = 0; eIrq = 0; eMret = 0; eRv = 0;
        eCause = '0; eTval = '0; ePc = '0; eRpc = '0;
        s = -1;
        if (!reset) begin
            mBusy = 0;
            irqQ.delete();
            for (int i = 0; i < SYNC; i++) irqQ.push_back(1'b0);
        end else begin
            sync = irqQ[0];
            if (mBusy) begin
                mAge++;
                eBusy = 1;
                if (mIsMret) begin
                    eMret = 1; eRv = 1; eRpc = mepc; mBusy = 0;
                end else if (mAge == D + 1) begin
                    eCommit = 1; eIrq = mIrq; eCause = mCause; eTval = mTval; ePc = mPc;
                end else if (mAge == D + 2) begin
                    eRv   = 1;
                    eRpc  = (mtvec & 32'hFFFF_FFFC) + ((mIrq && mtvec[1:0] == 2'b01) ? 32'(mCause) * 4 : 0);
                    mBusy = 0;
                end
            end else begin
                for (int i = 2; i >= 0; i--) if (s < 0 && excValid[i]) s = i;
                if (s >= 0) begin
                    eFlush = 1; mBusy = 1; mIsMret = 0; mAge = 0; mIrq = 0;
                    mCause = excCause[4*s +: 4];
                    mTval  = excTval[32*s +: 32];
                    mPc    = excPC[32*s +: 32];
                end else if (mretRequest) begin
                    eFlush = 1; mBusy = 1; mIsMret = 1; mAge = 0;
                end else if (sync && mstatusMie && mieMeie) begin
                    eFlush = 1; mBusy = 1; mIsMret = 0; mAge = 0; mIrq = 1;
                    mCause = 4'd11; mTval = '0; mPc = retirePC;
                end
            end
            irqQ.push_back(interrupt);
            void'(irqQ.pop_front());
        end
        checkOutput("ctl", {25'd0, flush, stall, busy, trapCommit, trapInterrupt, mretCommit, redirectValid},
                           {25'd0, eFlush, eBusy, eBusy, eCommit, eIrq, eMret, eRv});
        checkOutput("trapCause", {28'd0, trapCause}, {28'd0, eCause});
        checkOutput("trapTval", trapTval, eTval);
        checkOutput("trapPC", trapPC, ePc);
        checkOutput("redirectPC", redirectPC, eRpc);
    endtask

    task automatic nextCycle();
        @(negedge clock);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            evalCycle();
            nextCycle();
        end
    endtask

    initial begin
        bit found;
        reset = 1'b0; interrupt = 1'b0; mstatusMie = 1'b0; mieMeie = 1'b0;
        retirePC = '0; mtvec = '0; mepc = '0;
        clearReq();
        irqQ.delete();
        for (int i = 0; i < SYNC; i++) irqQ.push_back(1'b0);
        @(negedge clock);
        excValid = 3'b111;
        evalCycle();
        checkOutput("resetFlush", {31'd0, flush}, 32'd0);
        nextCycle();
        clearReq();
        cycles(1);
        reset = 1'b1;
        cycles(3);

        $display("[TB] execute illegal-instruction fault");
        mtvec = 32'h200;
        applyStimulus(3'b010, 1, 4'd2, 32'h73, 32'h100);
        evalCycle();
        checkOutput("t1Flush", {31'd0, flush}, 32'd1);
        nextCycle();
        clearReq();
        cycles(2);
        evalCycle();
        checkOutput("t1Commit", {31'd0, trapCommit}, 32'd1);
        checkOutput("t1Cause", {28'd0, trapCause}, 32'd2);
        checkOutput("t1Tval", trapTval, 32'h73);
        checkOutput("t1PC", trapPC, 32'h100);
        nextCycle();
        evalCycle();
        checkOutput("t1Redirect", {31'd0, redirectValid}, 32'd1);
        checkOutput("t1RedirectPC", redirectPC, 32'h200);
        nextCycle();
        cycles(3);

        $display("[TB] simultaneous memory and decode faults");
        applyStimulus(3'b100, 2, 4'd5, 32'hAAAA, 32'h108);
        applyStimulus(3'b001, 0, 4'd2, 32'hBBBB, 32'h110);
        evalCycle();
        nextCycle();
        clearReq();
        cycles(2);
        evalCycle();
        checkOutput("t2Cause", {28'd0, trapCause}, 32'd5);
        checkOutput("t2PC", trapPC, 32'h108);
        nextCycle();
        cycles(5);

        $display("[TB] vectored external interrupt");
        interrupt = 1'b1; mstatusMie = 1'b1; mieMeie = 1'b1;
        retirePC = 32'h340; mtvec = 32'h401;
        found = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            evalCycle();
            if (flush) found = 1;
            nextCycle();
        end
        checkOutput("t3IrqTaken", {31'd0, found}, 32'd1);
        mstatusMie = 1'b0;
        cycles(2);
        evalCycle();
        checkOutput("t3Commit", {31'd0, trapCommit}, 32'd1);
        checkOutput("t3Intr", {31'd0, trapInterrupt}, 32'd1);
        checkOutput("t3Cause", {28'd0, trapCause}, 32'd11);
        checkOutput("t3Tval", trapTval, 32'd0);
        checkOutput("t3PC", trapPC, 32'h340);
        nextCycle();
        evalCycle();
        checkOutput("t3RedirectPC", redirectPC, 32'h42C);
        nextCycle();
        interrupt = 1'b0;
        cycles(4);

        $display("[TB] masked interrupt then enabled");
        interrupt = 1'b1; mstatusMie = 1'b0;
        for (int i = 0; i < 6; i++) begin
            evalCycle();
            checkOutput("t4Masked", {31'd0, flush}, 32'd0);
            nextCycle();
        end
        mstatusMie = 1'b1;
        evalCycle();
        checkOutput("t4Enabled", {31'd0, flush}, 32'd1);
        nextCycle();
        mstatusMie = 1'b0; interrupt = 1'b0;
        cycles(6);

        $display("[TB] mret");
        mepc = 32'h1234;
        mretRequest = 1'b1;
        evalCycle();
        checkOutput("t5Flush", {31'd0, flush}, 32'd1);
        nextCycle();
        clearReq();
        evalCycle();
        checkOutput("t5Mret", {31'd0, mretCommit}, 32'd1);
        checkOutput("t5Redirect", {31'd0, redirectValid}, 32'd1);
        checkOutput("t5RedirectPC", redirectPC, 32'h1234);
        nextCycle();
        cycles(2);
        mretRequest = 1'b1;
        applyStimulus(3'b100, 2, 4'd7, 32'h55, 32'h3000);
        evalCycle();
        nextCycle();
        clearReq();
        evalCycle();
        checkOutput("t5bNoMret", {31'd0, mretCommit}, 32'd0);
        nextCycle();
        cycles(6);

        $display("[TB] reset during drain");
        applyStimulus(3'b010, 1, 4'd3, 32'h9, 32'h500);
        evalCycle();
        nextCycle();
        clearReq();
        evalCycle();
        checkOutput("t6InDrain", {31'd0, stall}, 32'd1);
        nextCycle();
        reset = 1'b0;
        evalCycle();
        checkOutput("t6RstStall", {31'd0, stall}, 32'd0);
        checkOutput("t6RstBusy", {31'd0, busy}, 32'd0);
        nextCycle();
        cycles(1);
        reset = 1'b1;
        cycles(8);

        $display("[TB] random traffic");
        for (int n = 0; n < 2000; n++) begin
            clearReq();
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 5) == 0) excValid = 3'($urandom_range(1, 7));
            excCause = 12'($urandom);
            excTval  = {$urandom, $urandom, $urandom};
            excPC    = {$urandom, $urandom, $urandom};
            mretRequest = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) interrupt = ~interrupt;
            mstatusMie = ($urandom_range(0, 3) != 0);
            mieMeie    = ($urandom_range(0, 3) != 0);
            retirePC   = $urandom;
            mtvec      = {$urandom_range(0, 32'h3FFF_FFFF), 1'b0, 1'($urandom_range(0, 1))};
            mepc       = $urandom;
            evalCycle();
            nextCycle();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
